sopc_bus_ctrl: RTL

- Parametrised memory-bus controller between the Immunity core's data port (ram_en / write_en / write_sel / addr / data) and NUM_SLAVES memory-mapped slaves (data RAM, peripherals).
- Replaces the direct core-to-data_ram wiring of the minimal SoC top.
- Adds address decode, programmable wait states, slave ready handshake, timeout and bus-error reporting, and a stall back to the core.

---
 rtl/sopc_bus_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/sopc_bus_ctrl.sv
// Memory-bus controller between the core data port and NUM_SLAVES memory-mapped slaves.
// Decodes the top address bits, inserts wait states, waits for slave ready, and reports errors.
module sopc_bus_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SEL_BITS    = 2,
    parameter int unsigned NUM_SLAVES  = 4,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             m_en,
    input  logic                             m_write_en,
    input  logic [DATA_WIDTH/8-1:0]          m_write_sel,
    input  logic [ADDR_WIDTH-1:0]            m_addr,
    input  logic [DATA_WIDTH-1:0]            m_write_data,
    output logic [DATA_WIDTH-1:0]            m_read_data,
    output logic                             m_stall,
    output logic                             bus_err,
    output logic [NUM_SLAVES-1:0]            s_en,
    output logic                             s_write_en,
    output logic [DATA_WIDTH/8-1:0]          s_write_sel,
    output logic [ADDR_WIDTH-1:0]            s_addr,
    output logic [DATA_WIDTH-1:0]            s_write_data,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_read_data,
    input  logic [NUM_SLAVES-1:0]            s_ready
);

    localparam int unsigned SEL_W = DATA_WIDTH / 8;
    localparam int unsigned TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_REQ,
        ST_RESP,
        ST_ERR
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            wait_q, wait_d;
    logic [TO_W-1:0]       to_q, to_d;
    logic [SEL_BITS-1:0]   idx_q, idx_d;
    logic                  we_q, we_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [NUM_SLAVES-1:0] s_en_d;
    logic                  s_we_d;
    logic [SEL_W-1:0]      s_sel_d;
    logic                  err_d;
    logic [SEL_BITS-1:0]   m_idx;
    logic [DATA_WIDTH-1:0] rd_sel;
    logic                  ready_sel;

    assign m_idx   = m_addr[ADDR_WIDTH-1 -: SEL_BITS];
    assign m_stall = rst & m_en & (state_q != ST_RESP) & (state_q != ST_ERR);

    // Read-data and ready mux for the latched slave index
    always_comb begin
        rd_sel    = '0;
        ready_sel = 1'b0;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            if (idx_q == SEL_BITS'(i)) begin
                rd_sel    = s_read_data[i*DATA_WIDTH +: DATA_WIDTH];
                ready_sel = s_ready[i];
            end
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        to_d    = to_q;
        idx_d   = idx_q;
        we_d    = we_q;
        sel_d   = sel_q;
        addr_d  = s_addr;
        wdata_d = s_write_data;
        rdata_d = m_read_data;

        case (state_q)
            ST_IDLE: begin
                if (m_en) begin
                    idx_d   = m_idx;
                    we_d    = m_write_en;
                    sel_d   = m_write_sel;
                    addr_d  = m_addr;
                    wdata_d = m_write_data;
                    if (32'(m_idx) >= NUM_SLAVES) begin
                        state_d = ST_ERR;
                    end else if (WAIT_CYCLES != 0) begin
                        state_d = ST_WAIT;
                        wait_d  = 8'(WAIT_CYCLES);
                    end else begin
                        state_d = ST_REQ;
                        to_d    = '0;
                    end
                end
            end
            ST_WAIT: begin
                wait_d = wait_q - 8'd1;
                if (wait_q == 8'd1) begin
                    state_d = ST_REQ;
                    to_d    = '0;
                end
            end
            ST_REQ: begin
                if (ready_sel) begin
                    if (!we_q) begin
                        rdata_d = rd_sel;
                    end
                    state_d = ST_RESP;
                end else if (TIMEOUT != 0) begin
                    if (to_q == TO_W'(TIMEOUT - 1)) begin
                        state_d = ST_ERR;
                    end else begin
                        to_d = to_q + TO_W'(1);
                    end
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_ERR) begin
            rdata_d = '0;
        end

        s_en_d = '0;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            s_en_d[i] = (state_d == ST_REQ) && (idx_d == SEL_BITS'(i));
        end
        s_we_d  = (state_d == ST_REQ) && we_d;
        s_sel_d = s_we_d ? sel_d : '0;
        err_d   = (state_d == ST_ERR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            wait_q       <= '0;
            to_q         <= '0;
            idx_q        <= '0;
            we_q         <= 1'b0;
            sel_q        <= '0;
            s_addr       <= '0;
            s_write_data <= '0;
            m_read_data  <= '0;
            s_en         <= '0;
            s_write_en   <= 1'b0;
            s_write_sel  <= '0;
            bus_err      <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            to_q         <= to_d;
            idx_q        <= idx_d;
            we_q         <= we_d;
            sel_q        <= sel_d;
            s_addr       <= addr_d;
            s_write_data <= wdata_d;
            m_read_data  <= rdata_d;
            s_en         <= s_en_d;
            s_write_en   <= s_we_d;
            s_write_sel  <= s_sel_d;
            bus_err      <= err_d;
        end
    end

endmodule
